// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - RUN/SET mode controller for the digital clock counter chain
//
// clock_set_deb: 2-flop synchronizer plus counting debouncer for one raw button.
//   clk, rst_n  : clock, asynchronous active-low reset
//   btn_raw     : raw asynchronous button (active-high)
//   level       : debounced button level
//
// clock_set_ctrl: debounces mode/inc buttons and runs the RUN/SET state machine.
//   clk, rst_n            : clock, asynchronous active-low reset
//   tick_1hz              : one-cycle pulse per second
//   btn_mode, btn_inc     : raw buttons
//   run_tick              : advance strobe to the seconds counter (RUN only)
//   sec_clr               : clear strobe to the seconds counter (leaving MIN_L)
//   set_hr_h .. set_min_l : per-digit increment strobes (set states only)
//   blink                 : blink phase for the selected digit
//   mode                  : 0 RUN, 1 HR_H, 2 HR_L, 3 MIN_H, 4 MIN_L

module clock_set_deb #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic [CW-1:0] cnt;

  // The level flips on the DEB_CYCLES-th consecutive sample that differs
  // from it; any agreeing sample restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module clock_set_ctrl #(
  parameter int DEB_CYCLES  = 16,
  parameter int REPEAT_DLY  = 1000,
  parameter int REPEAT_RATE = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       run_tick,
  output logic       sec_clr,
  output logic       set_hr_h,
  output logic       set_hr_l,
  output logic       set_min_h,
  output logic       set_min_l,
  output logic       blink,
  output logic [2:0] mode
);
  localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_HR_H  = 3'd1,
    ST_HR_L  = 3'd2,
    ST_MIN_H = 3'd3,
    ST_MIN_L = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic          mode_lvl, mode_lvl_q;
  logic          inc_lvl, inc_lvl_q;
  logic          mode_press, inc_press;
  logic          rep_on, rep_on_nx;
  logic          rep_phase, rep_phase_nx;   // 0: waiting REPEAT_DLY, 1: REPEAT_RATE
  logic [RW-1:0] rep_cnt, rep_cnt_nx;
  logic [RW-1:0] rep_target;
  logic          rep_fire, set_state, inc_evt;
  logic          run_tick_nx, sec_clr_nx, blink_nx;
  logic          hr_h_nx, hr_l_nx, min_h_nx, min_l_nx;

  clock_set_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_mode),
    .level   (mode_lvl)
  );

  clock_set_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_inc),
    .level   (inc_lvl)
  );

  assign mode_press = mode_lvl & ~mode_lvl_q;
  assign inc_press  = inc_lvl & ~inc_lvl_q;
  assign set_state  = (state != ST_RUN);
  assign rep_target = rep_phase ? RW'(REPEAT_RATE) : RW'(REPEAT_DLY);
  // rep_cnt holds the number of edges since the press (or last repeat).
  assign rep_fire   = rep_on & inc_lvl & (rep_cnt == rep_target);
  // A mode event in the same cycle swallows any inc event.
  assign inc_evt    = set_state & (inc_press | rep_fire) & ~mode_press;
  assign mode       = state;

  always_comb begin
    state_nx     = state;
    run_tick_nx  = 1'b0;
    sec_clr_nx   = 1'b0;
    hr_h_nx      = 1'b0;
    hr_l_nx      = 1'b0;
    min_h_nx     = 1'b0;
    min_l_nx     = 1'b0;
    rep_on_nx    = rep_on;
    rep_phase_nx = rep_phase;
    rep_cnt_nx   = rep_cnt;
    blink_nx     = blink;

    // Only the current state gates run_tick, so a tick on the MIN_L->RUN
    // edge is dropped and sec_clr stays the only strobe.
    run_tick_nx = tick_1hz & (state == ST_RUN);

    if (mode_press) begin
      case (state)
        ST_RUN:   state_nx = ST_HR_H;
        ST_HR_H:  state_nx = ST_HR_L;
        ST_HR_L:  state_nx = ST_MIN_H;
        ST_MIN_H: state_nx = ST_MIN_L;
        default: begin
          state_nx   = ST_RUN;
          sec_clr_nx = 1'b1;
        end
      endcase
      rep_on_nx    = 1'b0;
      rep_phase_nx = 1'b0;
      rep_cnt_nx   = '0;
    end else begin
      if (inc_evt) begin
        case (state)
          ST_HR_H:  hr_h_nx  = 1'b1;
          ST_HR_L:  hr_l_nx  = 1'b1;
          ST_MIN_H: min_h_nx = 1'b1;
          ST_MIN_L: min_l_nx = 1'b1;
          default:  ;
        endcase
      end
      if (set_state && inc_press) begin
        rep_on_nx    = 1'b1;
        rep_phase_nx = 1'b0;
        rep_cnt_nx   = RW'(1);
      end else if (!inc_lvl || !rep_on) begin
        rep_on_nx    = 1'b0;
        rep_phase_nx = 1'b0;
        rep_cnt_nx   = '0;
      end else if (rep_fire) begin
        rep_phase_nx = 1'b1;
        rep_cnt_nx   = RW'(1);
      end else begin
        rep_cnt_nx = rep_cnt + 1'b1;
      end
    end

    // Leaving RUN always lands in HR_H, so "in RUN" covers entry to HR_H.
    if (state == ST_RUN || state_nx == ST_RUN) begin
      blink_nx = 1'b0;
    end else if (tick_1hz) begin
      blink_nx = ~blink;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      mode_lvl_q <= 1'b0;
      inc_lvl_q  <= 1'b0;
      rep_on     <= 1'b0;
      rep_phase  <= 1'b0;
      rep_cnt    <= '0;
      run_tick   <= 1'b0;
      sec_clr    <= 1'b0;
      set_hr_h   <= 1'b0;
      set_hr_l   <= 1'b0;
      set_min_h  <= 1'b0;
      set_min_l  <= 1'b0;
      blink      <= 1'b0;
    end else begin
      state      <= state_nx;
      mode_lvl_q <= mode_lvl;
      inc_lvl_q  <= inc_lvl;
      rep_on     <= rep_on_nx;
      rep_phase  <= rep_phase_nx;
      rep_cnt    <= rep_cnt_nx;
      run_tick   <= run_tick_nx;
      sec_clr    <= sec_clr_nx;
      set_hr_h   <= hr_h_nx;
      set_hr_l   <= hr_l_nx;
      set_min_h  <= min_h_nx;
      set_min_l  <= min_l_nx;
      blink      <= blink_nx;
    end
  end
endmodule
